// File: rtl/p10_nanov_serial_alu.sv
// Bit-serial ALU stage for the nanoV core.
// Operands arrive LSB-first, one bit per clock, over a 32-cycle run indexed
// by counter_o, which this block owns and drives to the register file.
// The block produces the serial rd stream with its write enable, end-of-run
// lt/eq flags, and an optional parallel copy of the result word.
module p10_nanov_serial_alu #(
    parameter bit EN_CAPTURE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic        data_rs1_i,
    input  logic        data_rs2_i,
    output logic        busy_o,
    output logic [4:0]  counter_o,
    output logic        data_rd_o,
    output logic        wr_en_o,
    output logic        done_o,
    output logic        lt_o,
    output logic        eq_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SLT   = 3'b101,
        OP_SLTU  = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    // Ops that compute A + ~B + 1 through the serial adder.
    function automatic logic uses_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    // Compare ops produce only a flag; the sequencer writes it back itself.
    function automatic logic is_cmp(input op_e op);
        return (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    state_e     state_q,   state_d;
    logic [4:0] counter_q, counter_d;
    op_e        op_q,      op_d;
    logic       carry_q,   carry_d;
    logic       eq_acc_q,  eq_acc_d;
    logic       lt_q,      lt_d;
    logic       eq_q,      eq_d;

    logic running;
    logic last_bit;
    logic b_eff;
    logic sum;
    logic carry_out;
    logic data_rd_raw;
    logic lt_final;

    assign running   = (state_q == S_RUN);
    assign last_bit  = running && (counter_q == 5'd31);

    // Serial full adder; B is inverted for the subtract family.
    assign b_eff     = data_rs2_i ^ uses_sub(op_q);
    assign sum       = data_rs1_i ^ b_eff ^ carry_q;
    assign carry_out = (data_rs1_i & b_eff) | (data_rs1_i & carry_q) | (b_eff & carry_q);

    // Per-bit result before gating with the RUN state.
    always_comb begin
        data_rd_raw = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: data_rd_raw = sum;
            OP_AND:         data_rd_raw = data_rs1_i & data_rs2_i;
            OP_OR:          data_rd_raw = data_rs1_i | data_rs2_i;
            OP_XOR:         data_rd_raw = data_rs1_i ^ data_rs2_i;
            OP_PASSB:       data_rd_raw = data_rs2_i;
            default:        data_rd_raw = 1'b0;
        endcase
    end

    // Less-than flag from the sign bits and the final adder bit; meaningful only on bit 31.
    always_comb begin
        lt_final = 1'b0;
        case (op_q)
            // Unsigned A < B exactly when A + ~B + 1 produces no carry out.
            OP_SLTU: lt_final = ~carry_out;
            // Differing signs decide directly; equal signs cannot overflow, so the difference sign decides.
            OP_SLT:  lt_final = (data_rs1_i ^ data_rs2_i) ? data_rs1_i : sum;
            default: lt_final = 1'b0;
        endcase
    end

    // Next-state logic for the run sequencer, carry chain and end-of-run flags.
    // NOTE: every _d takes its _q value before any branch, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        op_d      = op_q;
        carry_d   = carry_q;
        eq_acc_d  = eq_acc_q;
        lt_d      = lt_q;
        eq_d      = eq_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                counter_d = 5'd0;
                if (start_i) begin
                    state_d  = S_RUN;
                    op_d     = op_e'(op_i);
                    carry_d  = uses_sub(op_e'(op_i));
                    eq_acc_d = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_RUN: begin
                carry_d  = carry_out;
                eq_acc_d = eq_acc_q & ~(data_rs1_i ^ data_rs2_i);
                if (last_bit) begin
                    state_d   = S_DONE;
                    counter_d = 5'd0;
                    lt_d      = lt_final;
                    eq_d      = eq_acc_q & ~(data_rs1_i ^ data_rs2_i);
                end else begin
                    counter_d = counter_q + 5'd1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                counter_d = 5'd0;
            end
        endcase
    end

    // Sequencer, datapath and flag registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            counter_q <= 5'd0;
            op_q      <= OP_ADD;
            carry_q   <= 1'b0;
            eq_acc_q  <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            eq_acc_q  <= eq_acc_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    generate
        if (EN_CAPTURE) begin : g_capture
            logic [31:0] result_q, result_d;

            // Shift each result bit in from the top so bit 0 lands in result[0] after 32 shifts.
            always_comb begin
                result_d = result_q;
                if (running) begin
                    result_d = {data_rd_raw, result_q[31:1]};
                    if (last_bit && is_cmp(op_q)) begin
                        result_d = {31'd0, lt_final};
                    end
                end
            end

            // Parallel result register; holds its value outside RUN.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    result_q <= 32'd0;
                end else begin
                    result_q <= result_d;
                end
            end

            assign result_o = result_q;
        end else begin : g_no_capture
            assign result_o = 32'd0;
        end
    endgenerate

    assign busy_o    = running;
    assign counter_o = counter_q;
    assign data_rd_o = running & data_rd_raw;
    assign wr_en_o   = running & ~is_cmp(op_q);
    assign done_o    = (state_q == S_DONE);
    assign lt_o      = lt_q;
    assign eq_o      = eq_q;

endmodule

// File: tb/tb_p10_nanov_serial_alu.sv
// Testbench for p10_nanov_serial_alu: directed runs with literal expectations
// plus a word-level reference model compared against the DUT every cycle.
module tb_p10_nanov_serial_alu;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110, PASSB = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        rs1, rs2;
    logic        busy, data_rd, wr_en, done, lt, eq;
    logic [4:0]  counter;
    logic [31:0] result;

    // Register-file emulation: operand words read by the DUT-owned bit index.
    logic [31:0] cur_a, cur_b;
    assign rs1 = cur_a[counter];
    assign rs2 = cur_b[counter];

    int total = 0;
    int bad   = 0;

    p10_nanov_serial_alu #(.EN_CAPTURE(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .data_rs1_i (rs1),
        .data_rs2_i (rs2),
        .busy_o     (busy),
        .counter_o  (counter),
        .data_rd_o  (data_rd),
        .wr_en_o    (wr_en),
        .done_o     (done),
        .lt_o       (lt),
        .eq_o       (eq),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    function automatic logic is_cmp(input logic [2:0] o);
        return (o == SLT) || (o == SLTU);
    endfunction

    function automatic logic model_lt(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o == SLT)  return $signed(a) < $signed(b);
        if (o == SLTU) return a < b;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            OR_:     return a | b;
            XOR_:    return a ^ b;
            PASSB:   return b;
            default: return {31'd0, model_lt(o, a, b)};
        endcase
    endfunction

    function automatic logic model_rd(input int ph, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        if (ph < 1 || ph > 32 || is_cmp(o)) return 1'b0;
        w = model_word(o, a, b);
        return w[ph-1];
    endfunction

    // m_phase: 0 idle, 1..32 serving bit m_phase-1, 33 done cycle.
    int          m_phase = 0;
    logic [2:0]  m_op    = 3'b000;
    logic [31:0] m_a     = '0, m_b = '0;
    logic        m_lt    = 1'b0, m_eq = 1'b0;
    logic [31:0] m_res   = '0;

    // Model advances on the same edge as the DUT, from the bench-driven inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_lt    <= 1'b0;
            m_eq    <= 1'b0;
            m_res   <= '0;
        end else if ((m_phase == 0 || m_phase == 33) && start) begin
            m_phase <= 1;
            m_op    <= op;
            m_a     <= cur_a;
            m_b     <= cur_b;
        end else if (m_phase >= 1 && m_phase <= 31) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == 32) begin
            m_phase <= 33;
            m_lt    <= model_lt(m_op, m_a, m_b);
            m_eq    <= (m_a == m_b);
            m_res   <= model_word(m_op, m_a, m_b);
        end else begin
            m_phase <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 32));
        check("counter", 32'(counter), (m_phase >= 1 && m_phase <= 32) ? 32'(m_phase - 1) : 32'd0);
        check("done", 32'(done), 32'(m_phase == 33));
        check("wr_en", 32'(wr_en), 32'(m_phase >= 1 && m_phase <= 32 && !is_cmp(m_op)));
        check("data_rd", 32'(data_rd), 32'(model_rd(m_phase, m_op, m_a, m_b)));
        if (m_phase == 0 || m_phase == 33) begin
            check("lt", 32'(lt), 32'(m_lt));
            check("eq", 32'(eq), 32'(m_eq));
            check("result", result, m_res);
        end
    end

    // ---------------- directed stimulus ----------------
    // Raise start now; it is accepted on the next rising edge.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        cur_a = a;
        cur_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Capture the 32-bit serial stream, then stop at the expected done cycle.
    task automatic collect(output logic [31:0] stream, output int wr_cnt);
        stream = '0;
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            stream[i] = data_rd;
            wr_cnt += int'(wr_en);
        end
        @(negedge clk);
    endtask

    logic [31:0] stream;
    int          wr_cnt;
    int          done_cnt;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        cur_a = '0;
        cur_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_data_rd", 32'(data_rd), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lt", 32'(lt), 32'd0);
        check("rst_eq", 32'(eq), 32'd0);
        check("rst_result", result, 32'd0);

        // ADD overflowing into the sign bit.
        launch(ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        collect(stream, wr_cnt);
        check("add_done", 32'(done), 32'd1);
        check("add_stream", stream, 32'h8000_0000);
        check("add_wr_cnt", 32'(wr_cnt), 32'd32);
        check("add_result", result, 32'h8000_0000);
        check("add_lt", 32'(lt), 32'd0);
        check("add_eq", 32'(eq), 32'd0);
        repeat (2) @(negedge clk);

        // SUB with borrow, then PASSB back-to-back from the done cycle.
        launch(SUB, 32'd5, 32'd7);
        collect(stream, wr_cnt);
        check("sub_done", 32'(done), 32'd1);
        check("sub_stream", stream, 32'hFFFF_FFFE);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_eq", 32'(eq), 32'd0);
        launch(PASSB, 32'hFFFF_0000, 32'h1234_5678);
        collect(stream, wr_cnt);
        check("passb_result", result, 32'h1234_5678);
        check("passb_stream", stream, 32'h1234_5678);
        @(negedge clk);

        // Signed vs unsigned compare of -1 and 1; no write-back for either.
        launch(SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(stream, wr_cnt);
        check("slt_lt", 32'(lt), 32'd1);
        check("slt_result", result, 32'h0000_0001);
        check("slt_wr_cnt", 32'(wr_cnt), 32'd0);
        check("slt_stream", stream, 32'd0);
        @(negedge clk);
        launch(SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(stream, wr_cnt);
        check("sltu_lt", 32'(lt), 32'd0);
        check("sltu_result", result, 32'd0);
        check("sltu_wr_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);

        // Sign-straddling compare pair: 1 vs 0x80000000.
        launch(SLT, 32'h0000_0001, 32'h8000_0000);
        collect(stream, wr_cnt);
        check("slt2_lt", 32'(lt), 32'd0);
        launch(SLTU, 32'h0000_0001, 32'h8000_0000);
        collect(stream, wr_cnt);
        check("sltu2_lt", 32'(lt), 32'd1);
        check("sltu2_result", result, 32'h0000_0001);
        @(negedge clk);

        // Equal operands, then AND with unequal operands back-to-back.
        launch(XOR_, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        collect(stream, wr_cnt);
        check("xor_result", result, 32'd0);
        check("xor_eq", 32'(eq), 32'd1);
        launch(AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        collect(stream, wr_cnt);
        check("and_result", result, 32'h00F0_00F0);
        check("and_eq", 32'(eq), 32'd0);
        repeat (2) @(negedge clk);

        // start held high mid-run with op changing: the run must be untouched.
        launch(OR_, 32'h1234_0000, 32'h0000_5678);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1;
                op    = SUB;
            end
            if (i == 20) start = 1'b0;
        end
        @(negedge clk);
        check("glitch_done", 32'(done), 32'd1);
        check("glitch_result", result, 32'h1234_5678);
        check("glitch_eq", 32'(eq), 32'd0);

        // start in the done cycle: new run begins with counter 0 the next cycle.
        launch(ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_counter", 32'(counter), 32'd0);
        repeat (31) @(negedge clk);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_result", result, 32'hFFFF_FFFE);
        check("b2b_eq", 32'(eq), 32'd1);
        @(negedge clk);

        // Model-checked runs over every op with pseudo-random operands.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            launch(3'(i % 8), ra, rb);
            collect(stream, wr_cnt);
            if (i % 3 == 0) @(negedge clk);
        end

        // Reset in the middle of a run: outputs clear and no done follows.
        @(negedge clk);
        launch(SUB, 32'd100, 32'd3);
        for (int i = 0; i < 16; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_counter", 32'(counter), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
